// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, LSB first,
// one full-subtractor cell and a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;

  logic             x, y, bi;
  logic             d_bit, b_bit;
  logic [WIDTH-1:0] sd_next;
  logic             last;

  assign x     = sa_q[0];
  assign y     = sb_q[0];
  assign bi    = br_q;
  assign d_bit = x ^ y ^ bi;
  assign b_bit = (~x & y) | (~x & bi) | (y & bi);
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    sd_next = sd_q >> 1;
    sd_next[WIDTH-1] = d_bit;
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sd_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sd_d  = sd_next;
        br_d  = b_bit;
        cnt_d = cnt_q + CW'(1);
        // Result registers change only here, on entry to DONE.
        if (last) begin
          diff_d  = sd_next;
          bo_d    = b_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed tables, corner
// sequences and random operands against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       start1, busy1, done1, bo1;
  logic [0:0] a1, b1, diff1;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .busy(busy1), .done(done1),
    .diff(diff1), .borrow_out(bo1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic d;
    logic bo;
  } vec1_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_,
                     input logic [7:0] ed, input logic eb,
                     input string nm);
    int n, nb;
    logic [7:0] pd;
    logic pb;
    bit held;
    pd = diff8; pb = bo8; held = 1; n = 0; nb = 0;
    @(negedge clk);
    start8 = 1; a8 = ta; b8 = tb_;
    @(posedge clk); #1;
    start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (!done8 && n < 20) begin
      if (busy8) nb++;
      if (diff8 !== pd || bo8 !== pb) held = 0;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, n, 8);
    chk({nm, " busy_cycles"}, nb, 8);
    chk({nm, " diff"}, diff8, ed);
    chk({nm, " borrow"}, bo8, eb);
    chk({nm, " hold"}, held, 1);
    chk({nm, " busy_with_done"}, busy8, 0);
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, done8, 0);
  endtask

  task automatic op1(input logic ta, input logic tb_,
                     input logic ed, input logic eb,
                     input string nm);
    int n;
    n = 0;
    @(negedge clk);
    start1 = 1; a1 = ta; b1 = tb_;
    @(posedge clk); #1;
    start1 = 0;
    chk({nm, " busy"}, busy1, 1);
    while (!done1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, n, 1);
    chk({nm, " diff"}, diff1, ed);
    chk({nm, " borrow"}, bo1, eb);
    @(posedge clk); #1;
  endtask

  task automatic count_done(input int cyc, output int nd);
    nd = 0;
    repeat (cyc) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
  endtask

  initial begin
    vec8_t t8[4];
    vec1_t t1[4];
    int n, nd;
    logic [7:0] ra, rb;

    t8[0] = '{8'd100, 8'd37, 8'd63, 1'b0};
    t8[1] = '{8'd37, 8'd100, 8'hC1, 1'b1};
    t8[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    t8[3] = '{8'h55, 8'h55, 8'h00, 1'b0};
    t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    t1[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
    t1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    t1[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 0;
    start8 = 0; a8 = '0; b8 = '0;
    start1 = 0; a1 = '0; b1 = '0;
    #1;
    chk("rst busy", busy8, 0);
    chk("rst done", done8, 0);
    chk("rst diff", diff8, 0);
    chk("rst borrow", bo8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    foreach (t8[i])
      op8(t8[i].a, t8[i].b, t8[i].d, t8[i].bo,
          $sformatf("vec%0d", i));

    // start pulsed in SHIFT and in DONE must be ignored
    @(negedge clk);
    start8 = 1; a8 = 8'd10; b8 = 8'd3;
    @(posedge clk); #1;
    start8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start8 = 1; a8 = 8'd200; b8 = 8'd100;
    @(negedge clk);
    start8 = 0;
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign diff", diff8, 7);
    chk("ign borrow", bo8, 0);
    @(negedge clk);
    start8 = 1; a8 = 8'd1; b8 = 8'd2;
    @(negedge clk);
    start8 = 0;
    count_done(15, nd);
    chk("ign extra_done", nd, 0);
    chk("ign diff_after", diff8, 7);

    // asynchronous reset in the 4th SHIFT cycle
    @(negedge clk);
    start8 = 1; a8 = 8'd50; b8 = 8'd7;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort busy", busy8, 0);
    chk("abort done", done8, 0);
    chk("abort diff", diff8, 0);
    chk("abort borrow", bo8, 0);
    @(negedge clk);
    rst_n = 1;
    count_done(15, nd);
    chk("abort no_done", nd, 0);
    op8(8'd200, 8'd1, 8'd199, 1'b0, "post_rst");

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8(ra, rb, 8'((int'(ra) - int'(rb) + 256) % 256),
          (int'(ra) < int'(rb)), $sformatf("rnd%0d", i));
    end

    foreach (t1[i])
      op1(t1[i].a, t1[i].b, t1[i].d, t1[i].bo,
          $sformatf("w1_%0d", i));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
